// File: rtl/score_pkg.sv
// Shared types and constants for the BCD score keeper and its 7-segment display.
package score_pkg;

  typedef enum logic [1:0] {IDLE, ADD, COMMIT} score_state_t;

  localparam int          NUM_DIGITS = 6;
  localparam logic [23:0] MAX_BCD    = 24'h999999;
  localparam logic [7:0]  SEG_OFF    = 8'hFF;

  // Active-low, bit7 = dp (off), bits 6:0 = g..a
  localparam logic [7:0] SEG_LUT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  function automatic logic [7:0] seg_of(input logic [3:0] digit);
    logic [7:0] seg;
    case (digit)
      4'd0:    seg = SEG_LUT[0];
      4'd1:    seg = SEG_LUT[1];
      4'd2:    seg = SEG_LUT[2];
      4'd3:    seg = SEG_LUT[3];
      4'd4:    seg = SEG_LUT[4];
      4'd5:    seg = SEG_LUT[5];
      4'd6:    seg = SEG_LUT[6];
      4'd7:    seg = SEG_LUT[7];
      4'd8:    seg = SEG_LUT[8];
      4'd9:    seg = SEG_LUT[9];
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd7seg_decoder.sv
// Registered BCD digit to active-low 7-segment pattern, with a blank override.
module bcd7seg_decoder
  import score_pkg::*;
#(
  parameter bit RST_BLANK = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [7:0] o_seg
);

  logic [7:0] r_seg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_seg <= RST_BLANK ? SEG_OFF : seg_of(4'd0);
    end else begin
      r_seg <= i_blank ? SEG_OFF : seg_of(i_digit);
    end
  end

  assign o_seg = r_seg;

endmodule

// File: rtl/score_hex_display.sv
// Running 6-digit BCD game score fed by event pulses; a digit-serial adder
// applies queued events one at a time and the committed value drives HEX5..HEX0.
module score_hex_display
  import score_pkg::*;
#(
  parameter logic [23:0] DIAMOND_BCD = 24'h000025,
  parameter logic [23:0] GOLD_BCD    = 24'h000500,
  parameter bit          BLANK_ZEROS = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_score,
  input  logic        player_eat_dimond,
  input  logic        player_eat_gold,
  output logic [23:0] score_bcd,
  output logic        busy,
  output logic        event_lost,
  output logic        saturated,
  output logic [7:0]  HEX0,
  output logic [7:0]  HEX1,
  output logic [7:0]  HEX2,
  output logic [7:0]  HEX3,
  output logic [7:0]  HEX4,
  output logic [7:0]  HEX5
);

  score_state_t r_state;
  logic [3:0]   r_pend_d, r_pend_g;
  logic [23:0]  r_work, r_addend, r_score;
  logic [2:0]   r_idx;
  logic         r_carry, r_lost, r_sat;

  logic         w_idle, w_take_g, w_take_d;
  logic [4:0]   w_lsb;
  logic [4:0]   w_add;
  logic [5:0]   w_blank;
  logic [7:0]   w_seg [NUM_DIGITS];

  // One BCD digit plus carry-in; returns {carry_out, digit}
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] a, input logic [3:0] b,
                                               input logic cin);
    logic [4:0] sum;
    sum = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    if (sum > 5'd9) return {1'b1, 4'(sum - 5'd10)};
    return {1'b0, sum[3:0]};
  endfunction

  function automatic logic [3:0] pend_next(input logic [3:0] p, input logic pulse,
                                           input logic take);
    if (pulse && !take && p != 4'd15) return p + 4'd1;
    if (take && !pulse)               return p - 4'd1;
    return p;
  endfunction

  assign w_idle   = (r_state == IDLE);
  assign w_take_g = w_idle && (r_pend_g != 4'd0);
  assign w_take_d = w_idle && (r_pend_g == 4'd0) && (r_pend_d != 4'd0);
  assign w_lsb    = {r_idx, 2'b00};
  assign w_add    = bcd_digit_add(r_work[w_lsb +: 4], r_addend[w_lsb +: 4], r_carry);

  always_ff @(posedge clk) begin
    if (reset || clear_score) begin
      r_state  <= IDLE;
      r_pend_d <= 4'd0;
      r_pend_g <= 4'd0;
      r_work   <= 24'd0;
      r_score  <= 24'd0;
      r_idx    <= 3'd0;
      r_carry  <= 1'b0;
      r_lost   <= 1'b0;
      r_sat    <= 1'b0;
    end else begin
      r_pend_d <= pend_next(r_pend_d, player_eat_dimond, w_take_d);
      r_pend_g <= pend_next(r_pend_g, player_eat_gold, w_take_g);
      if ((player_eat_dimond && !w_take_d && r_pend_d == 4'd15) ||
          (player_eat_gold && !w_take_g && r_pend_g == 4'd15))
        r_lost <= 1'b1;

      case (r_state)
        IDLE: begin
          // Once saturated, a take just drains the counter and stays idle
          if ((w_take_g || w_take_d) && !r_sat) begin
            r_addend <= w_take_g ? GOLD_BCD : DIAMOND_BCD;
            r_idx    <= 3'd0;
            r_carry  <= 1'b0;
            r_state  <= ADD;
          end
        end
        ADD: begin
          r_work[w_lsb +: 4] <= w_add[3:0];
          r_carry            <= w_add[4];
          if (r_idx == 3'd5) r_state <= COMMIT;
          else               r_idx   <= r_idx + 3'd1;
        end
        COMMIT: begin
          if (r_carry) begin
            r_work  <= MAX_BCD;
            r_score <= MAX_BCD;
            r_sat   <= 1'b1;
          end else begin
            r_score <= r_work;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign score_bcd  = r_score;
  assign busy       = !w_idle || (r_pend_d != 4'd0) || (r_pend_g != 4'd0);
  assign event_lost = r_lost;
  assign saturated  = r_sat;

  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    w_blank    = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above && (r_score[4*k +: 4] == 4'd0);
      w_blank[k] = BLANK_ZEROS && (k != 0) && zero_above;
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dec
    bcd7seg_decoder #(
      .RST_BLANK(BLANK_ZEROS && (k != 0))
    ) u_dec (
      .i_clk  (clk),
      .i_rst  (reset),
      .i_digit(r_score[4*k +: 4]),
      .i_blank(w_blank[k]),
      .o_seg  (w_seg[k])
    );
  end

  assign HEX0 = w_seg[0];
  assign HEX1 = w_seg[1];
  assign HEX2 = w_seg[2];
  assign HEX3 = w_seg[3];
  assign HEX4 = w_seg[4];
  assign HEX5 = w_seg[5];

endmodule

// File: tb/tb_score_hex_display.sv
// Bench for score_hex_display: integer-arithmetic reference model of the score,
// queues and event timing, with per-scenario tasks and randomized traffic.
module tb_score_hex_display;

  logic        clk = 1'b0;
  logic        reset, clear_score, player_eat_dimond, player_eat_gold;
  logic [23:0] score_bcd;
  logic        busy, event_lost, saturated;
  logic [7:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [7:0]  hx [6];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (plain integers)
  int m_score, m_pd, m_pg, m_rem, m_val, m_prev_score;
  bit m_lost, m_sat, m_was_rst;

  localparam logic [7:0] TB_SEG [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                         8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  score_hex_display dut (
    .clk(clk), .reset(reset), .clear_score(clear_score),
    .player_eat_dimond(player_eat_dimond), .player_eat_gold(player_eat_gold),
    .score_bcd(score_bcd), .busy(busy), .event_lost(event_lost), .saturated(saturated),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
  );

  always #5 clk = ~clk;

  always_comb begin
    hx[0] = HEX0; hx[1] = HEX1; hx[2] = HEX2;
    hx[3] = HEX3; hx[4] = HEX4; hx[5] = HEX5;
  end

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int t;
    r = '0;
    t = v;
    for (int k = 0; k < 6; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] exp_hex(input int v, input int k);
    int p;
    p = 1;
    for (int j = 0; j < k; j++) p = p * 10;
    if (k > 0 && v < p) return 8'hFF;
    return TB_SEG[(v / p) % 10];
  endfunction

  // Drive one cycle of inputs, let the DUT sample them, advance the model.
  task automatic tick(input bit d, input bit g, input bit clr, input bit rst);
    bit idle, tg, td;
    int s;
    player_eat_dimond = d;
    player_eat_gold   = g;
    clear_score       = clr;
    reset             = rst;
    m_prev_score      = m_score;
    @(posedge clk);
    m_was_rst = rst;
    if (rst || clr) begin
      m_score = 0; m_pd = 0; m_pg = 0; m_rem = 0; m_lost = 0; m_sat = 0;
    end else begin
      idle = (m_rem == 0);
      tg   = idle && m_pg != 0;
      td   = idle && m_pg == 0 && m_pd != 0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          s = m_score + m_val;
          if (s > 999999) begin m_score = 999999; m_sat = 1; end
          else m_score = s;
        end
      end
      if ((tg || td) && !m_sat) begin
        m_rem = 7;
        m_val = tg ? 500 : 25;
      end
      if (g && !tg) begin if (m_pg == 15) m_lost = 1; else m_pg++; end
      else if (tg && !g) m_pg--;
      if (d && !td) begin if (m_pd == 15) m_lost = 1; else m_pd++; end
      else if (td && !d) m_pd--;
    end
    #1;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      tick(0, 0, 0, 0);
    end
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
  endtask

  task automatic test_reset;
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    n_checks++;
    if (score_bcd !== 24'h0) begin n_fail++; $display("FAIL reset_score got %h want 000000", score_bcd); end
    n_checks++;
    if (busy !== 1'b0 || event_lost !== 1'b0 || saturated !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got busy=%b lost=%b sat=%b want 000", busy, event_lost, saturated);
    end
    n_checks++;
    if (HEX0 !== 8'hC0) begin n_fail++; $display("FAIL reset_hex0 got %h want c0", HEX0); end
    for (int k = 1; k < 6; k++) begin
      n_checks++;
      if (hx[k] !== 8'hFF) begin n_fail++; $display("FAIL reset_hex%0d got %h want ff", k, hx[k]); end
    end
  endtask

  task automatic test_single_diamond;
    tick(1, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      tick(0, 0, 0, 0);
      if (i < 8) begin
        n_checks++;
        if (score_bcd !== 24'h0) begin n_fail++; $display("FAIL single_early c%0d got %h want 000000", i, score_bcd); end
      end
    end
    n_checks++;
    if (score_bcd !== 24'h000025) begin n_fail++; $display("FAIL single_latency got %h want 000025", score_bcd); end
    tick(0, 0, 0, 0);
    n_checks++;
    if (HEX0 !== 8'h92 || HEX1 !== 8'hA4) begin
      n_fail++; $display("FAIL single_hex10 got %h %h want 92 a4", HEX0, HEX1);
    end
    for (int k = 2; k < 6; k++) begin
      n_checks++;
      if (hx[k] !== 8'hFF) begin n_fail++; $display("FAIL single_blank%0d got %h want ff", k, hx[k]); end
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy got %b want 0", busy); end
  endtask

  task automatic test_simultaneous;
    tick(0, 0, 0, 1);
    tick(1, 1, 0, 0);
    for (int i = 1; i <= 40; i++) begin
      tick(i <= 3, 0, 0, 0);
      if (i == 8) begin
        n_checks++;
        if (score_bcd !== 24'h000500) begin n_fail++; $display("FAIL simul_gold_first got %h want 000500", score_bcd); end
      end
      n_checks++;
      if (score_bcd !== to_bcd(m_score)) begin
        n_fail++; $display("FAIL simul_track c%0d got %h want %h", i, score_bcd, to_bcd(m_score));
      end
    end
    n_checks++;
    if (score_bcd !== 24'h000600 || event_lost !== 1'b0) begin
      n_fail++; $display("FAIL simul_final got %h lost=%b want 000600 lost=0", score_bcd, event_lost);
    end
  endtask

  task automatic spaced_events(input int n, input bit gold);
    for (int i = 0; i < n; i++) begin
      tick(!gold, gold, 0, 0);
      repeat (7) tick(0, 0, 0, 0);
    end
  endtask

  task automatic test_carry_saturation;
    bit ok;
    tick(0, 0, 0, 1);
    spaced_events(40, 1'b1);
    drain(ok);
    n_checks++;
    if (!ok || score_bcd !== 24'h020000) begin n_fail++; $display("FAIL preload got %h ok=%b want 020000", score_bcd, ok); end
    spaced_events(1959, 1'b1);
    spaced_events(19, 1'b0);
    drain(ok);
    n_checks++;
    if (!ok || score_bcd !== 24'h999975 || saturated !== 1'b0 || event_lost !== 1'b0) begin
      n_fail++; $display("FAIL run_up got %h sat=%b lost=%b want 999975 0 0", score_bcd, saturated, event_lost);
    end
    // 999975 + 25 carries out of the top digit, so this clamps
    spaced_events(1, 1'b0);
    drain(ok);
    n_checks++;
    if (!ok || score_bcd !== 24'h999999 || saturated !== 1'b1) begin
      n_fail++; $display("FAIL clamp got %h sat=%b want 999999 1", score_bcd, saturated);
    end
    spaced_events(1, 1'b1);
    drain(ok);
    n_checks++;
    if (!ok || score_bcd !== 24'h999999 || saturated !== 1'b1 || score_bcd !== to_bcd(m_score)) begin
      n_fail++; $display("FAIL hold_sat got %h sat=%b want 999999 1", score_bcd, saturated);
    end
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (hx[k] !== 8'h90) begin n_fail++; $display("FAIL sat_hex%0d got %h want 90", k, hx[k]); end
    end
  endtask

  task automatic test_pending_overflow;
    bit ok;
    tick(0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      tick(1, 0, 0, 0);
      n_checks++;
      if (busy !== 1'b1 || event_lost !== m_lost) begin
        n_fail++; $display("FAIL ovf_flags c%0d got busy=%b lost=%b want 1 %b", i, busy, event_lost, m_lost);
      end
    end
    drain(ok);
    n_checks++;
    if (!ok || busy !== 1'b0) begin n_fail++; $display("FAIL ovf_drain got busy=%b want 0", busy); end
    n_checks++;
    if (event_lost !== 1'b1) begin n_fail++; $display("FAIL ovf_lost got %b want 1", event_lost); end
    n_checks++;
    if (score_bcd !== to_bcd(m_score)) begin
      n_fail++; $display("FAIL ovf_score got %h want %h", score_bcd, to_bcd(m_score));
    end
  endtask

  task automatic test_clear_mid_add;
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 1, 0);
    n_checks++;
    if (score_bcd !== 24'h0 || busy !== 1'b0 || event_lost !== 1'b0) begin
      n_fail++; $display("FAIL clear_now got %h busy=%b lost=%b want 000000 0 0", score_bcd, busy, event_lost);
    end
    for (int i = 0; i < 12; i++) begin
      tick(0, 0, 0, 0);
      n_checks++;
      if (score_bcd !== 24'h0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL clear_late c%0d got %h busy=%b want 000000 0", i, score_bcd, busy);
      end
    end
  endtask

  task automatic test_random;
    bit d, g, c;
    for (int i = 0; i < 1500; i++) begin
      d = ($urandom_range(0, 5) == 0);
      g = ($urandom_range(0, 9) == 0);
      c = ($urandom_range(0, 299) == 0);
      tick(d, g, c, 0);
      n_checks++;
      if (score_bcd !== to_bcd(m_score) || busy !== (m_rem != 0 || m_pd != 0 || m_pg != 0) ||
          event_lost !== m_lost || saturated !== m_sat) begin
        n_fail++;
        $display("FAIL rand_state c%0d got %h b%b l%b s%b want %h l%b s%b", i, score_bcd, busy,
                 event_lost, saturated, to_bcd(m_score), m_lost, m_sat);
      end
      for (int k = 0; k < 6; k++) begin
        n_checks++;
        if (hx[k] !== exp_hex(m_prev_score, k)) begin
          n_fail++; $display("FAIL rand_hex%0d c%0d got %h want %h", k, i, hx[k], exp_hex(m_prev_score, k));
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; clear_score = 1'b0; player_eat_dimond = 1'b0; player_eat_gold = 1'b0;
    m_score = 0; m_pd = 0; m_pg = 0; m_rem = 0; m_val = 0; m_prev_score = 0;
    m_lost = 0; m_sat = 0; m_was_rst = 1;
    test_reset;
    test_single_diamond;
    test_simultaneous;
    test_carry_saturation;
    test_pending_overflow;
    test_clear_mid_add;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
